icache_refill_ctrl: RTL

- Miss-refill sequencer between the I-cache miss logic and the AHB-Lite master port.
- On an accepted miss it issues one read WRAP4 burst, critical word first, and sequences the NONSEQ/SEQ address phases against hready.
- It streams the four returned words into the line buffer and reports completion or an AHB error.

---
 rtl/icache_refill_ctrl_pkg.sv | 34 +++
 rtl/icache_wrap4_addr_gen.sv | 38 +++
 rtl/icache_refill_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared AHB-Lite encodings plus the constants and state type used by the I-cache refill sequencer.
package icache_refill_ctrl_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } trans_type_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } burst_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NSEQ  = 2'd1,
        ST_BURST = 2'd2,
        ST_ERR   = 2'd3
    } refill_state_e;

    localparam logic [31:0] LINE_BASE_MASK = 32'hFFFF_FFF0;
    localparam logic [2:0]  HSIZE_WORD     = 3'b010;
    // Beats per refill; the WRAP4 sequencing below only works for 4.
    localparam int          BEATS          = 4;

endpackage

// File: rtl/icache_wrap4_addr_gen.sv
// Holds the line base and the wrapping word offset of the current refill and
// derives the AHB address and the line-buffer word index from them.
module icache_wrap4_addr_gen
    import icache_refill_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_load,
    input  logic [31:0] i_addr,
    input  logic        i_adv,
    input  logic [1:0]  i_data_cnt,
    output logic [31:0] o_haddr,
    output logic [1:0]  o_idx
);

    logic [31:0] r_base;
    logic [1:0]  r_off;
    logic [1:0]  r_crit;

    // Offset is 2 bits wide, so both address and index wrap inside the line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_base <= 32'h0;
            r_off  <= 2'd0;
            r_crit <= 2'd0;
        end else if (i_load) begin
            r_base <= i_addr & LINE_BASE_MASK;
            r_off  <= i_addr[3:2];
            r_crit <= i_addr[3:2];
        end else if (i_adv) begin
            r_off  <= r_off + 2'd1;
        end
    end

    assign o_haddr = r_base | {28'h0, r_off, 2'b00};
    assign o_idx   = r_crit + i_data_cnt;

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss refill sequencer: one critical-word-first WRAP4 read burst on
// AHB-Lite per accepted miss, streaming the returned words into the line buffer.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        miss_req,
    input  logic [31:0] miss_addr,
    output logic        miss_ready,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic [2:0]  hburst,
    output logic [2:0]  hsize,
    output logic        hwrite,
    input  logic        hready,
    input  logic        hresp,
    input  logic [31:0] hrdata,
    output logic        refill_we,
    output logic [1:0]  refill_idx,
    output logic [31:0] refill_data,
    output logic        refill_first,
    output logic        refill_done,
    output logic        refill_err
);

    refill_state_e r_state;
    refill_state_e w_state_next;
    logic [2:0]    r_addr_cnt;
    logic [1:0]    r_data_cnt;

    logic          w_accept;
    logic          w_beat;
    logic          w_addr_open;
    logic          w_last;
    logic          w_nseq_go;
    logic [31:0]   w_gen_addr;
    logic [1:0]    w_gen_idx;

    assign w_accept    = miss_req && (r_state == ST_IDLE);
    assign w_nseq_go   = (r_state == ST_NSEQ) && hready;
    assign w_beat      = (r_state == ST_BURST) && hready && !hresp;
    assign w_addr_open = r_addr_cnt < 3'(BEATS);
    assign w_last      = w_beat && (r_data_cnt == 2'(BEATS - 1));

    icache_wrap4_addr_gen u_addr_gen (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_accept),
        .i_addr     ({miss_addr[31:2], 2'b00}),
        .i_adv      (w_nseq_go || (w_beat && w_addr_open)),
        .i_data_cnt (r_data_cnt),
        .o_haddr    (w_gen_addr),
        .o_idx      (w_gen_idx)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (miss_req) w_state_next = ST_NSEQ;
            ST_NSEQ:  if (hready)   w_state_next = ST_BURST;
            // An error seen together with hready is taken as the second error cycle.
            ST_BURST: begin
                if (hresp)       w_state_next = hready ? ST_IDLE : ST_ERR;
                else if (w_last) w_state_next = ST_IDLE;
            end
            ST_ERR:   if (hready)   w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr_cnt <= 3'd0;
            r_data_cnt <= 2'd0;
        end else if (w_accept) begin
            r_addr_cnt <= 3'd0;
            r_data_cnt <= 2'd0;
        end else if (w_nseq_go) begin
            r_addr_cnt <= 3'd1;
        end else if (w_beat) begin
            r_data_cnt <= r_data_cnt + 2'd1;
            if (w_addr_open) r_addr_cnt <= r_addr_cnt + 3'd1;
        end
    end

    // Address-phase outputs depend on registered state only; strobes qualify on hready.
    always_comb begin
        miss_ready   = 1'b0;
        htrans       = TRANS_IDLE;
        hburst       = BURST_SINGLE;
        haddr        = 32'h0;
        refill_we    = 1'b0;
        refill_first = 1'b0;
        refill_done  = 1'b0;
        refill_err   = 1'b0;
        unique case (r_state)
            ST_IDLE: miss_ready = 1'b1;
            ST_NSEQ: begin
                htrans = TRANS_NONSEQ;
                hburst = BURST_WRAP4;
                haddr  = w_gen_addr;
            end
            ST_BURST: begin
                htrans       = w_addr_open ? TRANS_SEQ : TRANS_IDLE;
                hburst       = BURST_WRAP4;
                haddr        = w_gen_addr;
                refill_we    = w_beat;
                refill_first = w_beat && (r_data_cnt == 2'd0);
                refill_done  = w_last;
                refill_err   = hresp && hready;
            end
            ST_ERR:  refill_err = hready;
            default: miss_ready = 1'b0;
        endcase
    end

    assign refill_idx  = w_gen_idx;
    assign refill_data = hrdata;
    assign hsize       = HSIZE_WORD;
    assign hwrite      = 1'b0;

endmodule
